sysbus_mem_responder: RTL

Memory-side responder for the Sysbus initiator protocol used by the core's fetch, page-walk and store engines. Accepts line-sized read and write requests on the request channel, stores data in an internal word array, and returns read lines as eight 64-bit beats on the response channel. It is the simulation and FPGA memory endpoint the core's bus controller talks to.

---
 rtl/sysbus_mem_responder.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/sysbus_mem_responder.sv
// Sysbus memory endpoint: accepts line reads/writes on the request channel and
// returns read lines as eight beats on the response channel.
module sysbus_mem_responder #(
  parameter int unsigned BUS_DATA_WIDTH = 64,
  parameter int unsigned BUS_TAG_WIDTH  = 13,
  parameter int unsigned MEM_WORDS      = 4096,
  parameter int unsigned READ_LATENCY   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  input  logic                      bus_respack,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int unsigned AddrW = $clog2(MEM_WORDS);
  localparam int unsigned LatW  = $clog2(READ_LATENCY + 1);
  localparam logic        SysbusRead = 1'b1;

  typedef enum logic [1:0] {StIdle, StRdWait, StRdResp, StWrData} state_e;

  state_e                    state_q, state_d;
  logic [AddrW-1:0]          base_q, base_d;
  logic [2:0]                beat_q, beat_d;
  logic [LatW-1:0]           lat_q, lat_d;
  logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
  logic                      reqack_q, reqack_d;
  logic                      respcyc_q, respcyc_d;
  logic [BUS_DATA_WIDTH-1:0] resp_q, resp_d;
  logic [BUS_TAG_WIDTH-1:0]  resptag_q, resptag_d;

  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                      accept;
  logic                      mem_we;
  logic [AddrW-1:0]          mem_waddr;
  logic [AddrW-1:0]          rd_addr;
  logic [BUS_DATA_WIDTH-1:0] rd_word;

  // Never accept on the edge that closes an ack cycle, so each beat costs two cycles.
  assign accept = bus_reqcyc && !reqack_q && (state_q == StIdle || state_q == StWrData);

  assign mem_we    = (state_q == StWrData) && accept;
  assign mem_waddr = base_q + AddrW'(beat_q);
  assign rd_addr   = (state_q == StRdResp) ? base_q + AddrW'(beat_q) + AddrW'(1) : base_q;
  assign rd_word   = mem[rd_addr];

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    beat_d    = beat_q;
    lat_d     = lat_q;
    tag_d     = tag_q;
    reqack_d  = accept;
    respcyc_d = respcyc_q;
    resp_d    = resp_q;
    resptag_d = resptag_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          // Word index wraps at the array size; low three bits select the word in the line.
          base_d = bus_req[AddrW+2:3] & ~AddrW'(7);
          tag_d  = bus_reqtag;
          beat_d = 3'd0;
          lat_d  = '0;
          state_d = (bus_reqtag[12] == SysbusRead) ? StRdWait : StWrData;
        end
      end
      StRdWait: begin
        if (lat_q == LatW'(READ_LATENCY - 1)) begin
          resp_d    = rd_word;
          respcyc_d = 1'b1;
          resptag_d = tag_q;
          state_d   = StRdResp;
        end else begin
          lat_d = lat_q + LatW'(1);
        end
      end
      StRdResp: begin
        if (bus_respack) begin
          if (beat_q == 3'd7) begin
            respcyc_d = 1'b0;
            resp_d    = '0;
            resptag_d = '0;
            beat_d    = 3'd0;
            state_d   = StIdle;
          end else begin
            beat_d = beat_q + 3'd1;
            resp_d = rd_word;
          end
        end
      end
      StWrData: begin
        if (accept) begin
          if (beat_q == 3'd7) begin
            beat_d  = 3'd0;
            state_d = StIdle;
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      base_q    <= '0;
      beat_q    <= '0;
      lat_q     <= '0;
      tag_q     <= '0;
      reqack_q  <= 1'b0;
      respcyc_q <= 1'b0;
      resp_q    <= '0;
      resptag_q <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      beat_q    <= beat_d;
      lat_q     <= lat_d;
      tag_q     <= tag_d;
      reqack_q  <= reqack_d;
      respcyc_q <= respcyc_d;
      resp_q    <= resp_d;
      resptag_q <= resptag_d;
    end
  end

  // Array contents survive reset so a cut-short write keeps its completed beats.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= bus_req;
    end
  end

  assign bus_reqack  = reqack_q;
  assign bus_respcyc = respcyc_q;
  assign bus_resp    = resp_q;
  assign bus_resptag = resptag_q;

endmodule
